hazard_scoreboard: RTL and testbench

- ID-stage producer-tracking and stall unit; the upstream counterpart of the EX-stage forwarding unit.
- Records destination register, write-enable and load flag of each instruction as it leaves ID.
- Ages those records through EX, MEM and WB slots.
- Asserts stall whenever forwarding cannot deliver a value in time: load-use in EX, and branch/jump-register operands consumed in ID.
- Drives PC/IF-ID hold and ID/EX bubble insertion.

---
 rtl/hazard_scoreboard_pkg.sv | 27 ++
 rtl/hazard_slot_reg.sv | 36 +++
 rtl/hazard_scoreboard.sv | 94 +++++++++
 tb/tb_hazard_scoreboard.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions for the ID-stage hazard scoreboard.
// Holds the producer record layout and the slot index constants.
package hazard_scoreboard_pkg;

   localparam int REG_BITS  = 3;
   localparam int NUM_SLOTS = 3;

   localparam int EX  = 0;
   localparam int MEM = 1;
   localparam int WB  = 2;

   typedef struct packed {
      logic                v;
      logic [REG_BITS-1:0] rd;
      logic                ld;
   } slot_t;

   // True when a live producer record writes a register that the ID instruction reads.
   function automatic logic src_match(input slot_t               slot,
                                      input logic                rs_used,
                                      input logic [REG_BITS-1:0] rs,
                                      input logic                rt_used,
                                      input logic [REG_BITS-1:0] rt);
      return slot.v & ((rs_used & (rs == slot.rd)) | (rt_used & (rt == slot.rd)));
   endfunction

endpackage

// File: rtl/hazard_slot_reg.sv
// One producer-record pipeline slot: async clear, hold when disabled,
// and optional bubble insertion on load.
module hazard_slot_reg
   import hazard_scoreboard_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  en_i,
   input  logic  bubble_i,
   input  slot_t slot_i,
   output slot_t slot_o
);

   slot_t slot_q;
   slot_t slot_d;

   always_comb begin
      slot_d = slot_q;
      if (en_i) begin
         slot_d = bubble_i ? '0 : slot_i;
      end
   end

   // NOTE: state registers use non-blocking assignments so every slot samples
   // its neighbour's pre-edge value and the records shift by exactly one stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign slot_o = slot_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage producer tracker and stall generator: ages destination records
// through EX/MEM/WB and stalls when forwarding cannot deliver in time.
module hazard_scoreboard #(
   parameter int REG_BITS = hazard_scoreboard_pkg::REG_BITS,
   parameter int CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [REG_BITS-1:0] RsId,
   input  logic [REG_BITS-1:0] RtId,
   input  logic                RsUsedId,
   input  logic                RtUsedId,
   input  logic                EarlyUseId,
   input  logic [REG_BITS-1:0] RdId,
   input  logic                RegWriteId,
   input  logic                MemReadId,
   input  logic                ValidId,
   input  logic                Flush,
   input  logic                Freeze,
   output logic                stall,
   output logic [CNT_BITS-1:0] stallCycles
);

   import hazard_scoreboard_pkg::*;

   slot_t slots [NUM_SLOTS];
   slot_t ex_rec;
   logic  ex_bubble;
   logic  match_ex;
   logic  match_mem;

   logic [CNT_BITS-1:0] cnt_q;
   logic [CNT_BITS-1:0] cnt_d;

   assign match_ex  = src_match(slots[EX],  RsUsedId, RsId, RtUsedId, RtId);
   assign match_mem = src_match(slots[MEM], RsUsedId, RsId, RtUsedId, RtId);

   // WB matches never stall: the register file writes before it is read.
   assign stall = ValidId & ((match_ex & slots[EX].ld)
                           | (EarlyUseId & match_ex)
                           | (EarlyUseId & match_mem & slots[MEM].ld));

   assign ex_rec    = '{v: RegWriteId, rd: RdId, ld: MemReadId};
   assign ex_bubble = stall | Flush | ~ValidId;

   hazard_slot_reg u_slot_ex (
      .clk      (clk),
      .rst      (rst),
      .en_i     (~Freeze),
      .bubble_i (ex_bubble),
      .slot_i   (ex_rec),
      .slot_o   (slots[EX])
   );

   hazard_slot_reg u_slot_mem (
      .clk      (clk),
      .rst      (rst),
      .en_i     (~Freeze),
      .bubble_i (1'b0),
      .slot_i   (slots[EX]),
      .slot_o   (slots[MEM])
   );

   hazard_slot_reg u_slot_wb (
      .clk      (clk),
      .rst      (rst),
      .en_i     (~Freeze),
      .bubble_i (1'b0),
      .slot_i   (slots[MEM]),
      .slot_o   (slots[WB])
   );

   // The WB record only retires producers; nothing here consumes its contents.
   logic unused_wb;
   assign unused_wb = ^slots[WB];

   always_comb begin
      cnt_d = cnt_q;
      if (stall && !Freeze && !(&cnt_q)) begin
         cnt_d = cnt_q + CNT_BITS'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign stallCycles = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: vector table with a scoreboard
// queue, plus reset and mid-stall reset sequences; a 2-bit-counter copy checks saturation.
module tb_hazard_scoreboard;

   localparam int RB = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [RB-1:0] rs_id, rt_id, rd_id;
   logic          rs_used, rt_used, early, reg_write, mem_read, valid_id, flush, freeze;
   logic          stall, stall_sat;
   logic [15:0]   cnt;
   logic [1:0]    cnt_sat;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   hazard_scoreboard #(.REG_BITS(RB), .CNT_BITS(16)) dut (
      .clk(clk), .rst(rst), .RsId(rs_id), .RtId(rt_id), .RsUsedId(rs_used),
      .RtUsedId(rt_used), .EarlyUseId(early), .RdId(rd_id), .RegWriteId(reg_write),
      .MemReadId(mem_read), .ValidId(valid_id), .Flush(flush), .Freeze(freeze),
      .stall(stall), .stallCycles(cnt)
   );

   hazard_scoreboard #(.REG_BITS(RB), .CNT_BITS(2)) dut_sat (
      .clk(clk), .rst(rst), .RsId(rs_id), .RtId(rt_id), .RsUsedId(rs_used),
      .RtUsedId(rt_used), .EarlyUseId(early), .RdId(rd_id), .RegWriteId(reg_write),
      .MemReadId(mem_read), .ValidId(valid_id), .Flush(flush), .Freeze(freeze),
      .stall(stall_sat), .stallCycles(cnt_sat)
   );

   typedef struct {
      bit          valid, rw, mr;
      logic [RB-1:0] rd;
      bit          rs_u;
      logic [RB-1:0] rs;
      bit          rt_u;
      logic [RB-1:0] rt;
      bit          early, flush, freeze;
      bit          exp_stall;
      int          exp_cnt;
   } vec_t;

   typedef struct {
      bit stall;
      int cnt;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];

   task automatic check(input string name, input int actual, input int expected);
      total++;
      if (actual == expected) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   function automatic vec_t mk(input bit valid, rw, mr, input int rd,
                               input bit rs_u, input int rs, input bit rt_u, input int rt,
                               input bit early_f, flush_f, freeze_f,
                               input bit es, input int ec);
      vec_t v;
      v.valid = valid; v.rw = rw; v.mr = mr; v.rd = RB'(rd);
      v.rs_u = rs_u; v.rs = RB'(rs); v.rt_u = rt_u; v.rt = RB'(rt);
      v.early = early_f; v.flush = flush_f; v.freeze = freeze_f;
      v.exp_stall = es; v.exp_cnt = ec;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      valid_id = v.valid; reg_write = v.rw; mem_read = v.mr; rd_id = v.rd;
      rs_used = v.rs_u; rs_id = v.rs; rt_used = v.rt_u; rt_id = v.rt;
      early = v.early; flush = v.flush; freeze = v.freeze;
   endtask

   initial begin
      vec_t nop;
      vec_t cur;
      exp_t e;
      int   sat;

      nop = mk(0,0,0,0, 0,0,0,0, 0,0,0, 0,0);

      // Fields: valid rw mr rd | rs_u rs rt_u rt | early flush freeze | stall cnt
      vecs.push_back(mk(1,0,0,0, 1,3,0,0, 0,0,0, 0,0)); //  0 store reads R3, slots empty
      vecs.push_back(mk(1,1,1,3, 0,0,0,0, 0,0,0, 0,0)); //  1 LD R3
      vecs.push_back(mk(1,1,0,6, 1,3,0,0, 0,0,0, 1,0)); //  2 ADD R6<-R3 load-use
      vecs.push_back(mk(1,1,0,6, 1,3,0,0, 0,0,0, 0,1)); //  3 ADD issues
      vecs.push_back(nop); vecs[$].exp_cnt = 1;           //  4
      vecs.push_back(nop); vecs[$].exp_cnt = 1;           //  5
      vecs.push_back(mk(1,1,0,2, 0,0,0,0, 0,0,0, 0,1)); //  6 ADD R2
      vecs.push_back(mk(1,0,0,0, 1,2,0,0, 1,0,0, 1,1)); //  7 BEQZ R2, ALU in EX
      vecs.push_back(mk(1,0,0,0, 1,2,0,0, 1,0,0, 0,2)); //  8 ALU in MEM, no stall
      vecs.push_back(mk(1,0,0,0, 1,2,0,0, 1,0,0, 0,2)); //  9 producer in WB
      vecs.push_back(mk(1,1,1,5, 0,0,0,0, 0,0,0, 0,2)); // 10 LD R5
      vecs.push_back(mk(1,0,0,0, 1,5,0,0, 1,0,0, 1,2)); // 11 JR R5, load in EX
      vecs.push_back(mk(1,0,0,0, 1,5,0,0, 1,0,0, 1,3)); // 12 load in MEM
      vecs.push_back(mk(1,0,0,0, 1,5,0,0, 1,0,0, 0,4)); // 13 released
      vecs.push_back(mk(1,1,1,4, 0,0,0,0, 0,0,0, 0,4)); // 14 LD R4
      vecs.push_back(mk(1,1,0,6, 0,0,1,4, 0,0,1, 1,4)); // 15 ADD Rt=R4, frozen
      vecs.push_back(mk(1,1,0,6, 0,0,1,4, 0,0,1, 1,4)); // 16
      vecs.push_back(mk(1,1,0,6, 0,0,1,4, 0,0,1, 1,4)); // 17
      vecs.push_back(mk(1,1,0,6, 0,0,1,4, 0,0,0, 1,4)); // 18 freeze drops
      vecs.push_back(mk(1,1,0,6, 0,0,1,4, 0,0,0, 0,5)); // 19 ADD issues
      vecs.push_back(mk(1,1,1,1, 0,0,0,0, 0,1,0, 0,5)); // 20 LD R1 flushed
      vecs.push_back(mk(1,1,0,7, 1,1,0,0, 0,0,0, 0,5)); // 21 reader of R1, no stall
      vecs.push_back(nop); vecs[$].exp_cnt = 5;           // 22
      vecs.push_back(mk(1,1,1,0, 0,0,0,0, 0,0,0, 0,5)); // 23 LD R0
      vecs.push_back(mk(1,1,0,6, 0,0,1,0, 0,0,0, 1,5)); // 24 R0 load-use
      vecs.push_back(mk(0,1,0,2, 1,0,0,0, 1,0,0, 0,6)); // 25 not valid: no stall, no record
      vecs.push_back(mk(1,0,0,0, 1,2,0,0, 1,0,0, 0,6)); // 26 BEQZ R2, nothing recorded
      vecs.push_back(mk(1,1,1,3, 0,0,0,0, 0,0,0, 0,6)); // 27 LD R3
      vecs.push_back(mk(1,1,0,3, 0,0,0,0, 0,0,0, 0,6)); // 28 ADDI R3
      vecs.push_back(mk(1,0,0,0, 1,3,0,0, 1,0,0, 1,6)); // 29 JR R3, two producers
      vecs.push_back(mk(1,0,0,0, 1,3,0,0, 1,0,0, 0,7)); // 30 youngest (ALU) decides
      vecs.push_back(mk(1,1,1,4, 0,0,0,0, 0,0,0, 0,7)); // 31 LD R4
      vecs.push_back(mk(1,1,0,4, 1,4,0,0, 0,1,0, 1,7)); // 32 load-use with Flush
      vecs.push_back(mk(1,0,0,0, 1,4,0,0, 1,0,0, 1,8)); // 33 BEQZ R4, load in MEM
      vecs.push_back(nop); vecs[$].exp_cnt = 9;           // 34

      // Reset with all ID inputs active.
      drive(mk(1,1,1,3, 1,3,1,3, 1,0,0, 0,0));
      repeat (2) @(negedge clk);
      check("reset_stall", int'(stall), 0);
      check("reset_cnt", int'(cnt), 0);
      check("reset_cnt_sat", int'(cnt_sat), 0);
      rst = 1'b0;
      drive(nop);

      foreach (vecs[i]) begin
         @(negedge clk);
         cur = vecs[i];
         drive(cur);
         e.stall = cur.exp_stall;
         e.cnt   = cur.exp_cnt;
         exp_q.push_back(e);
         #1;
         e   = exp_q.pop_front();
         sat = (e.cnt > 3) ? 3 : e.cnt;
         check($sformatf("v%0d_stall", i), int'(stall), int'(e.stall));
         check($sformatf("v%0d_cnt", i), int'(cnt), e.cnt);
         check($sformatf("v%0d_stall_sat", i), int'(stall_sat), int'(e.stall));
         check($sformatf("v%0d_cnt_sat", i), int'(cnt_sat), sat);
      end

      // Reset asserted in the middle of a load-use stall.
      @(negedge clk);
      drive(mk(1,1,1,3, 0,0,0,0, 0,0,0, 0,0));
      @(negedge clk);
      drive(mk(1,1,0,6, 1,3,0,0, 0,0,0, 0,0));
      #1;
      check("midrst_pre_stall", int'(stall), 1);
      check("midrst_pre_cnt", int'(cnt), 9);
      #1 rst = 1'b1;
      #1;
      check("midrst_stall", int'(stall), 0);
      check("midrst_cnt", int'(cnt), 0);
      check("midrst_cnt_sat", int'(cnt_sat), 0);
      @(negedge clk);
      rst = 1'b0;
      drive(nop);
      @(negedge clk);
      #1;
      check("post_rst_stall", int'(stall), 0);
      check("post_rst_cnt", int'(cnt), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
